// File: rtl/lab_quantize_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lab_quantize_stage                                                         |
// | Rounds Q8.23 L/a*/b* to integers, clamps to CIELAB range, emits 8-bit      |
// | channels (3-cycle pipeline) and reports per-frame clipped-pixel counts.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lab_quantize_stage #(
    parameter int FRAME_PIXELS = 1552256,
    parameter int CNT_W        = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [31:0]      L_data,
    input  logic [31:0]      A_data,
    input  logic [31:0]      B_data,
    output logic             out_valid,
    output logic             out_sof,
    output logic [7:0]       L_q,
    output logic [7:0]       A_q,
    output logic [7:0]       B_q,
    output logic             out_clip,
    output logic             frame_done,
    output logic [CNT_W-1:0] clip_count,
    output logic             frame_err
);

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_PIXELS - 1);
    localparam logic signed [9:0] L_MAX    = 10'sd100;
    localparam logic signed [9:0] AB_MIN   = -10'sd128;
    localparam logic signed [9:0] AB_MAX   = 10'sd127;
    localparam logic [32:0]       HALF_LSB = 33'd4194304;

    // Half-up rounding: the 33-bit sum keeps 0x7FFFFFFF + 0.5 from wrapping.
    function automatic logic signed [9:0] round_q823(input logic [31:0] x);
        logic [32:0] sum;
        sum = {x[31], x} + HALF_LSB;
        return sum[32:23];
    endfunction

    // Returns {clip, value}.
    function automatic logic [8:0] clamp_l(input logic signed [9:0] v);
        if (v < 10'sd0)
            return {1'b1, 8'd0};
        else if (v > L_MAX)
            return {1'b1, 8'd100};
        else
            return {1'b0, v[7:0]};
    endfunction

    function automatic logic [8:0] clamp_ab(input logic signed [9:0] v);
        if (v < AB_MIN)
            return {1'b1, 8'h80};
        else if (v > AB_MAX)
            return {1'b1, 8'h7F};
        else
            return {1'b0, v[7:0]};
    endfunction

    logic              s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d;
    logic signed [9:0] s1_l_q, s1_l_d, s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic              s2_valid_q, s2_valid_d, s2_sof_q, s2_sof_d, s2_clip_q, s2_clip_d;
    logic [7:0]        s2_l_q, s2_l_d, s2_a_q, s2_a_d, s2_b_q, s2_b_d;
    logic              s3_valid_q, s3_valid_d, s3_sof_q, s3_sof_d, s3_clip_q, s3_clip_d;
    logic [7:0]        s3_l_q, s3_l_d, s3_a_q, s3_a_d, s3_b_q, s3_b_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d, clip_run_q, clip_run_d;
    logic [CNT_W-1:0]  clip_count_q, clip_count_d;
    logic              frame_done_q, frame_done_d, frame_err_q, frame_err_d;
    logic [8:0]        l_clamped, a_clamped, b_clamped;
    logic [CNT_W-1:0]  clip_inc;

    always_comb begin
        // Stage 1: rounding; channel data only moves with a valid pixel
        s1_valid_d = in_valid;
        s1_sof_d   = in_valid & in_sof;
        s1_l_d     = in_valid ? round_q823(L_data) : s1_l_q;
        s1_a_d     = in_valid ? round_q823(A_data) : s1_a_q;
        s1_b_d     = in_valid ? round_q823(B_data) : s1_b_q;

        // Stage 2: clamp
        l_clamped  = clamp_l(s1_l_q);
        a_clamped  = clamp_ab(s1_a_q);
        b_clamped  = clamp_ab(s1_b_q);
        s2_valid_d = s1_valid_q;
        s2_sof_d   = s1_sof_q;
        s2_l_d     = s1_valid_q ? l_clamped[7:0] : s2_l_q;
        s2_a_d     = s1_valid_q ? a_clamped[7:0] : s2_a_q;
        s2_b_d     = s1_valid_q ? b_clamped[7:0] : s2_b_q;
        s2_clip_d  = s1_valid_q ? (l_clamped[8] | a_clamped[8] | b_clamped[8]) : s2_clip_q;

        // Stage 3: output register
        s3_valid_d = s2_valid_q;
        s3_sof_d   = s2_sof_q;
        s3_l_d     = s2_valid_q ? s2_l_q    : s3_l_q;
        s3_a_d     = s2_valid_q ? s2_a_q    : s3_a_q;
        s3_b_d     = s2_valid_q ? s2_b_q    : s3_b_q;
        s3_clip_d  = s2_valid_q ? s2_clip_q : s3_clip_q;
    end

    // Frame accounting; pix_cnt_q == 0 means no frame is open
    always_comb begin
        pix_cnt_d    = pix_cnt_q;
        clip_run_d   = clip_run_q;
        clip_count_d = clip_count_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        clip_inc     = {{(CNT_W-1){1'b0}}, s3_clip_q};
        if (s3_valid_q) begin
            if (s3_sof_q) begin
                frame_err_d = (pix_cnt_q != '0);
                pix_cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                clip_run_d  = clip_inc;
            end else if (pix_cnt_q != '0) begin
                if (pix_cnt_q == LAST_IDX) begin
                    frame_done_d = 1'b1;
                    clip_count_d = clip_run_q + clip_inc;
                    pix_cnt_d    = '0;
                    clip_run_d   = '0;
                end else begin
                    pix_cnt_d  = pix_cnt_q + 1'b1;
                    clip_run_d = clip_run_q + clip_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_sof_q     <= 1'b0;
            s1_l_q       <= '0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s2_valid_q   <= 1'b0;
            s2_sof_q     <= 1'b0;
            s2_clip_q    <= 1'b0;
            s2_l_q       <= '0;
            s2_a_q       <= '0;
            s2_b_q       <= '0;
            s3_valid_q   <= 1'b0;
            s3_sof_q     <= 1'b0;
            s3_clip_q    <= 1'b0;
            s3_l_q       <= '0;
            s3_a_q       <= '0;
            s3_b_q       <= '0;
            pix_cnt_q    <= '0;
            clip_run_q   <= '0;
            clip_count_q <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sof_q     <= s1_sof_d;
            s1_l_q       <= s1_l_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s2_valid_q   <= s2_valid_d;
            s2_sof_q     <= s2_sof_d;
            s2_clip_q    <= s2_clip_d;
            s2_l_q       <= s2_l_d;
            s2_a_q       <= s2_a_d;
            s2_b_q       <= s2_b_d;
            s3_valid_q   <= s3_valid_d;
            s3_sof_q     <= s3_sof_d;
            s3_clip_q    <= s3_clip_d;
            s3_l_q       <= s3_l_d;
            s3_a_q       <= s3_a_d;
            s3_b_q       <= s3_b_d;
            pix_cnt_q    <= pix_cnt_d;
            clip_run_q   <= clip_run_d;
            clip_count_q <= clip_count_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign out_valid  = s3_valid_q;
    assign out_sof    = s3_sof_q;
    assign L_q        = s3_l_q;
    assign A_q        = s3_a_q;
    assign B_q        = s3_b_q;
    assign out_clip   = s3_clip_q;
    assign frame_done = frame_done_q;
    assign clip_count = clip_count_q;
    assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lab_quantize_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lab_quantize_stage                                                      |
// | Directed + randomized bench with an arithmetic reference model.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lab_quantize_stage;

    localparam int FP = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [31:0]   L_data = '0;
    logic [31:0]   A_data = '0;
    logic [31:0]   B_data = '0;
    logic          out_valid, out_sof, out_clip, frame_done, frame_err;
    logic [7:0]    L_q, A_q, B_q;
    logic [CW-1:0] clip_count;

    always #5 clk = ~clk;

    lab_quantize_stage #(.FRAME_PIXELS(FP), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .L_data(L_data), .A_data(A_data), .B_data(B_data),
        .out_valid(out_valid), .out_sof(out_sof), .L_q(L_q), .A_q(A_q), .B_q(B_q),
        .out_clip(out_clip), .frame_done(frame_done), .clip_count(clip_count),
        .frame_err(frame_err)
    );

    typedef struct { int due; logic sof; logic [7:0] l; logic [7:0] a; logic [7:0] b; logic clip; } pix_t;
    typedef struct { int due; logic done; logic err; int cc; } evt_t;

    pix_t pq[$];
    evt_t eq[$];
    int   ecount = 0;
    int   n_pass = 0;
    int   n_chk  = 0;
    int   m_cnt  = 0;
    int   m_run  = 0;
    int   exp_cc = 0;

    // Round half-up of x / 2^23 using floor division on plain integers.
    function automatic int round_lab(input logic [31:0] x);
        longint s;
        s = longint'($signed(x)) + 64'sd4194304;
        if (s >= 0) return int'(s / 64'sd8388608);
        return -int'((-s + 64'sd8388607) / 64'sd8388608);
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic pix_t model_pix(input logic [31:0] l, input logic [31:0] a, input logic [31:0] b);
        pix_t p;
        int rl, ra, rb;
        rl = round_lab(l);
        ra = round_lab(a);
        rb = round_lab(b);
        p.due  = 0;
        p.sof  = 1'b0;
        p.l    = 8'(clampi(rl, 0, 100));
        p.a    = 8'(clampi(ra, -128, 127));
        p.b    = 8'(clampi(rb, -128, 127));
        p.clip = (rl < 0) || (rl > 100) || (ra < -128) || (ra > 127) || (rb < -128) || (rb > 127);
        return p;
    endfunction

    function automatic pix_t mk(input logic [7:0] l, input logic [7:0] a, input logic [7:0] b, input logic c);
        pix_t p;
        p.due = 0; p.sof = 1'b0; p.l = l; p.a = a; p.b = b; p.clip = c;
        return p;
    endfunction

    function automatic logic [31:0] q823(input int ip);
        longint v;
        v = (longint'(ip) <<< 23) + longint'($urandom_range(0, 8388607));
        return v[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, ecount);
    endtask

    // Frame bookkeeping in terms of "pixels seen in the open frame".
    task automatic frame_model(input logic s, input logic c, input int due);
        evt_t ev;
        ev.due = due; ev.done = 1'b0; ev.err = 1'b0; ev.cc = 0;
        if (s) begin
            if (m_cnt > 0) begin
                ev.err = 1'b1;
                eq.push_back(ev);
            end
            m_cnt = 1;
            m_run = int'(c);
        end else if (m_cnt > 0) begin
            m_cnt++;
            m_run += int'(c);
            if (m_cnt == FP) begin
                ev.done = 1'b1;
                ev.cc   = m_run;
                eq.push_back(ev);
                m_cnt = 0;
                m_run = 0;
            end
        end
    endtask

    task automatic sample();
        logic exp_done, exp_err;
        evt_t ev;
        pix_t p;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (eq.size() > 0 && eq[0].due == ecount) begin
            ev = eq.pop_front();
            exp_done = ev.done;
            exp_err  = ev.err;
            if (ev.done) exp_cc = ev.cc;
        end
        chk("frame_done", 32'(frame_done), 32'(exp_done));
        chk("frame_err", 32'(frame_err), 32'(exp_err));
        chk("clip_count", 32'(clip_count), 32'(exp_cc));
        if (pq.size() > 0 && pq[0].due == ecount) begin
            p = pq.pop_front();
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("L_q", 32'(L_q), 32'(p.l));
            chk("A_q", 32'(A_q), 32'(p.a));
            chk("B_q", 32'(B_q), 32'(p.b));
            chk("out_sof", 32'(out_sof), 32'(p.sof));
            chk("out_clip", 32'(out_clip), 32'(p.clip));
        end else begin
            chk("out_valid_idle", 32'(out_valid), 32'd0);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [31:0] l, input logic [31:0] a,
                        input logic [31:0] b, input pix_t e);
        pix_t q;
        q = e;
        in_valid = v; in_sof = s; L_data = l; A_data = a; B_data = b;
        if (v) begin
            q.due = ecount + 3;
            q.sof = s;
            pq.push_back(q);
            frame_model(s, q.clip, ecount + 4);
        end
        @(posedge clk);
        #1;
        ecount++;
        sample();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, mk(8'd0, 8'd0, 8'd0, 1'b0));
    endtask

    task automatic send_rand(input logic s, input logic want_clip);
        logic [31:0] l, a, b;
        l = q823(int'($urandom_range(0, 99)));
        a = q823(int'($urandom_range(0, 254)) - 128);
        b = q823(int'($urandom_range(0, 254)) - 128);
        if (want_clip) begin
            case ($urandom_range(0, 2))
                0:       l = q823(int'($urandom_range(101, 200)));
                1:       a = q823(-int'($urandom_range(130, 200)));
                default: b = q823(int'($urandom_range(128, 200)));
            endcase
        end
        step(1'b1, s, l, a, b, model_pix(l, a, b));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        @(posedge clk);
        #1;
        ecount++;
        pq.delete();
        eq.delete();
        m_cnt = 0; m_run = 0; exp_cc = 0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_clip_count", 32'(clip_count), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] clip_mask;
        clip_mask = 16'h8492;

        do_reset();
        idle(2);

        // Rounding, isolated so latency is exact
        step(1'b1, 1'b0, 32'h19400000, 32'hFF400000, 32'h01400000, mk(8'd51, 8'hFF, 8'h03, 1'b0));
        idle(4);

        // Clamp corners
        step(1'b1, 1'b0, 32'h32800000, 32'h00000000, 32'h00000000, mk(8'd100, 8'h00, 8'h00, 1'b1));
        step(1'b1, 1'b0, 32'hFFE00000, 32'h00000000, 32'h00000000, mk(8'd0, 8'h00, 8'h00, 1'b0));
        step(1'b1, 1'b0, 32'h00000000, 32'h4B000000, 32'h80000000, mk(8'd0, 8'h7F, 8'h80, 1'b1));
        step(1'b1, 1'b0, 32'h00000000, 32'h00000000, 32'h7FFFFFFF, mk(8'd0, 8'h00, 8'h7F, 1'b1));
        step(1'b1, 1'b0, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, mk(8'd100, 8'h80, 8'h7F, 1'b1));
        idle(4);

        // Full contiguous frame, 5 clipped pixels
        for (int i = 0; i < FP; i++) send_rand(i == 0, clip_mask[i]);
        idle(4);
        chk("full_frame_clip_count", 32'(clip_count), 32'd5);

        // Gapped frame
        for (int i = 0; i < 2 * FP; i++) begin
            if (i % 2 == 0) send_rand(i == 0, $urandom_range(0, 3) == 0);
            else idle(1);
        end
        idle(4);

        // Short frame then a complete one
        for (int i = 0; i < 9; i++) send_rand(i == 0, $urandom_range(0, 2) == 0);
        for (int i = 0; i < FP; i++) send_rand(i == 0, $urandom_range(0, 2) == 0);
        idle(4);

        // Random traffic with gaps, stray pixels and random sof
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else send_rand($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
        end
        idle(4);

        // Reset with two pixels in flight
        send_rand(1'b1, 1'b0);
        send_rand(1'b0, 1'b1);
        do_reset();
        idle(3);
        for (int i = 0; i < FP; i++) send_rand(i == 0, clip_mask[i]);
        idle(4);
        chk("post_reset_clip_count", 32'(clip_count), 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
